// File: rtl/pingpong_feature_buffer.sv
// Ping-pong feature-map buffer: the writer fills one bank while the reader drains the other.
// Each bank carries a word count and a layer tag. The synchronous RAM read lands in a
// 2-entry skid FIFO, so the read side can stall without losing words already fetched.
module pingpong_feature_buffer #(
    parameter int unsigned DATA_W  = 40,
    parameter int unsigned DEPTH   = 49,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned LAYER_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [DATA_W-1:0]  i_wr_data,
    input  logic               i_wr_last,
    input  logic [LAYER_W-1:0] i_wr_layer,
    output logic               o_rd_valid,
    input  logic               i_rd_ready,
    output logic [DATA_W-1:0]  o_rd_data,
    output logic               o_rd_last,
    output logic [LAYER_W-1:0] o_rd_layer,
    output logic [1:0]         o_bank_full,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StStream} rd_state_e;

    // Storage: two banks, not reset
    logic [DATA_W-1:0]  r_mem [2][DEPTH];

    // Write side state
    logic               r_wr_bank;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [CNT_W-1:0]   r_cnt [2];
    logic [LAYER_W-1:0] r_layer [2];
    logic [1:0]         r_bank_full;

    // Read side state
    rd_state_e          r_state;
    logic               r_rd_bank;
    logic [CNT_W-1:0]   r_rd_addr;
    logic [CNT_W-1:0]   r_rd_cnt;
    logic [LAYER_W-1:0] r_rd_layer;

    // Skid FIFO
    logic [DATA_W-1:0]  r_sk_data [2];
    logic [1:0]         r_sk_last;
    logic               r_sk_rptr;
    logic               r_sk_wptr;
    logic [1:0]         r_sk_cnt;

    // Combinational signals
    logic               w_wr_ready;
    logic               w_wr_fire;
    logic               w_commit;
    logic               w_rd_valid;
    logic               w_pop;
    logic               w_release;
    logic               w_sk_room;
    logic               w_issue;
    logic               w_issue_last;
    logic               w_latch;
    logic [1:0]         w_bank_full_next;
    rd_state_e          w_state_next;

    // Handshake and commit/release decode
    always_comb begin
        w_wr_ready   = ~r_bank_full[r_wr_bank];
        w_wr_fire    = i_wr_valid && w_wr_ready;
        w_commit     = w_wr_fire && (i_wr_last || (r_wr_addr == ADDR_W'(DEPTH - 1)));
        w_rd_valid   = (r_sk_cnt != 2'd0);
        w_pop        = w_rd_valid && i_rd_ready;
        w_release    = w_pop && r_sk_last[r_sk_rptr];
        // A slot frees this cycle if the head is popped, so a full skid can still accept
        w_sk_room    = (r_sk_cnt != 2'd2) || w_pop;
        w_issue_last = (r_rd_addr == (r_rd_cnt - CNT_W'(1)));
    end

    // Write pointer, per-bank count and layer tag; commit flips to the other bank
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_cnt[0]   <= '0;
            r_cnt[1]   <= '0;
            r_layer[0] <= '0;
            r_layer[1] <= '0;
        end else if (w_wr_fire) begin
            if (r_wr_addr == '0) begin
                r_layer[r_wr_bank] <= i_wr_layer;
            end
            if (w_commit) begin
                r_cnt[r_wr_bank] <= {1'b0, r_wr_addr} + CNT_W'(1);
                r_wr_bank        <= ~r_wr_bank;
                r_wr_addr        <= '0;
            end else begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
        end
    end

    // RAM write port
    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_bank][r_wr_addr] <= i_wr_data;
        end
    end

    // Bank-full flags: commit and release never target the same bank in one cycle
    always_comb begin
        w_bank_full_next = r_bank_full;
        if (w_commit) begin
            w_bank_full_next[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_bank_full_next[r_rd_bank] = 1'b0;
        end
    end

    // Read FSM next-state: wait for a committed bank, prime address 0, then stream
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_bank_full[r_rd_bank]) begin
                    w_latch      = 1'b1;
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                w_issue      = 1'b1;
                w_state_next = StStream;
            end
            StStream: begin
                w_issue = (r_rd_addr < r_rd_cnt) && w_sk_room;
                if (w_release) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Read FSM state, read pointer and per-frame latched count/tag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rd_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_cnt    <= '0;
            r_rd_layer  <= '0;
            r_bank_full <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_bank_full <= w_bank_full_next;
            if (w_latch) begin
                r_rd_cnt   <= r_cnt[r_rd_bank];
                r_rd_layer <= r_layer[r_rd_bank];
                r_rd_addr  <= '0;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + CNT_W'(1);
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Skid FIFO: the synchronous RAM read lands directly in the tail slot
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
            r_sk_last    <= 2'b00;
            r_sk_rptr    <= 1'b0;
            r_sk_wptr    <= 1'b0;
            r_sk_cnt     <= 2'd0;
        end else begin
            if (w_issue) begin
                r_sk_data[r_sk_wptr] <= r_mem[r_rd_bank][r_rd_addr[ADDR_W-1:0]];
                r_sk_last[r_sk_wptr] <= w_issue_last;
                r_sk_wptr            <= ~r_sk_wptr;
            end
            if (w_pop) begin
                r_sk_rptr <= ~r_sk_rptr;
            end
            r_sk_cnt <= r_sk_cnt + {1'b0, w_issue} - {1'b0, w_pop};
        end
    end

    // Output mapping
    always_comb begin
        o_wr_ready  = w_wr_ready;
        o_rd_valid  = w_rd_valid;
        o_rd_data   = r_sk_data[r_sk_rptr];
        o_rd_last   = w_rd_valid && r_sk_last[r_sk_rptr];
        o_rd_layer  = r_rd_layer;
        o_bank_full = r_bank_full;
        o_full      = &r_bank_full;
        o_empty     = (r_bank_full == 2'b00) && (r_sk_cnt == 2'd0);
    end

endmodule

// File: tb/tb_pingpong_feature_buffer.sv
// Directed bench for the ping-pong feature buffer. Words to write and words expected
// back are kept in two queues; each scenario task fills them and drives the DUT.
module tb_pingpong_feature_buffer;

    typedef struct packed {
        logic [39:0] data;
        logic        last;
        logic [2:0]  layer;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [39:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [2:0]  wr_layer = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [39:0] rd_data;
    logic        rd_last;
    logic [2:0]  rd_layer;
    logic [1:0]  bank_full;
    logic        full;
    logic        empty;

    int errors = 0;
    int checks = 0;

    word_t wq[$];
    word_t eq[$];

    bit          stalled = 1'b0;
    logic [39:0] h_data;
    logic        h_last;
    logic [2:0]  h_layer;
    bit          chk_rise = 1'b0;
    bit          rise_pend = 1'b0;

    always #5 clk = ~clk;

    pingpong_feature_buffer #(
        .DATA_W (40),
        .DEPTH  (49),
        .ADDR_W (6),
        .LAYER_W(3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wr_valid (wr_valid),
        .o_wr_ready (wr_ready),
        .i_wr_data  (wr_data),
        .i_wr_last  (wr_last),
        .i_wr_layer (wr_layer),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_data  (rd_data),
        .o_rd_last  (rd_last),
        .o_rd_layer (rd_layer),
        .o_bank_full(bank_full),
        .o_full     (full),
        .o_empty    (empty)
    );

    // Queue one frame; layer is only meaningful on the first word, later words carry junk
    task automatic push_frame(input int len, input logic [2:0] layer, input bit use_last,
                              input bit rnd, input logic [39:0] base);
        word_t       w;
        word_t       e;
        logic [63:0] t;
        logic [39:0] d;
        for (int i = 0; i < len; i++) begin
            t = {$urandom(), $urandom()};
            d = rnd ? t[39:0] : base + 40'(i);
            w.data  = d;
            w.last  = use_last && (i == len - 1);
            w.layer = (i == 0) ? layer : ~layer;
            wq.push_back(w);
            e.data  = d;
            e.last  = (i == len - 1);
            e.layer = layer;
            eq.push_back(e);
        end
    endtask

    // One clock: drive inputs, score the handshakes that the coming edge will perform
    task automatic step(input bit rdy);
        word_t e;
        rd_ready = rdy;
        if (wq.size() > 0) begin
            wr_valid = 1'b1;
            wr_data  = wq[0].data;
            wr_last  = wq[0].last;
            wr_layer = wq[0].layer;
        end else begin
            wr_valid = 1'b0;
            wr_last  = 1'b0;
        end
        if (rise_pend) begin
            checks++;
            if (wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL wr_ready_rise: got %b, need 1 one cycle after release", wr_ready);
            end
            rise_pend = 1'b0;
        end
        if (stalled) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== h_data || rd_last !== h_last ||
                rd_layer !== h_layer) begin
                errors++;
                $display("FAIL stall_hold: got v=%b d=%h l=%b t=%0d, need v=1 d=%h l=%b t=%0d",
                         rd_valid, rd_data, rd_last, rd_layer, h_data, h_last, h_layer);
            end
        end
        if (wr_valid && wr_ready) begin
            void'(wq.pop_front());
        end
        if (rd_valid && rd_ready) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL rd_extra: got d=%h l=%b, need no word", rd_data, rd_last);
            end else begin
                e = eq.pop_front();
                if (rd_data !== e.data || rd_last !== e.last || rd_layer !== e.layer) begin
                    errors++;
                    $display("FAIL rd_word: got d=%h l=%b t=%0d, need d=%h l=%b t=%0d",
                             rd_data, rd_last, rd_layer, e.data, e.last, e.layer);
                end
                if (chk_rise && e.last) begin
                    checks++;
                    if (wr_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL wr_ready_wait: got %b, need 0 at release", wr_ready);
                    end
                    chk_rise  = 1'b0;
                    rise_pend = 1'b1;
                end
            end
        end
        stalled = rd_valid && !rd_ready;
        h_data  = rd_data;
        h_last  = rd_last;
        h_layer = rd_layer;
        @(negedge clk);
    endtask

    // Run until everything written has been read and the buffer reports empty
    task automatic drain(input bit rnd, input int budget, input string name);
        int n = 0;
        while ((wq.size() > 0 || eq.size() > 0 || empty !== 1'b1) && n < budget) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checks++;
        if (wq.size() > 0 || eq.size() > 0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain: got wq=%0d eq=%0d empty=%b, need 0 0 1 in %0d cycles",
                     name, wq.size(), eq.size(), empty, budget);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rd_ready = 1'b0;
        wq.delete();
        eq.delete();
        stalled   = 1'b0;
        chk_rise  = 1'b0;
        rise_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b need 1", wr_ready); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid: got %b need 0", rd_valid); end
        if (rd_last !== 1'b0) begin errors++; $display("FAIL rst_rd_last: got %b need 0", rd_last); end
        if (rd_data !== 40'h0) begin errors++; $display("FAIL rst_rd_data: got %h need 0", rd_data); end
        if (rd_layer !== 3'd0) begin errors++; $display("FAIL rst_rd_layer: got %0d need 0", rd_layer); end
        if (bank_full !== 2'b00) begin errors++; $display("FAIL rst_bank_full: got %b need 00", bank_full); end
        if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b need 0", full); end
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b need 1", empty); end
    endtask

    // 49 words with no wr_last: commit comes from the depth limit
    task automatic test_full_frame();
        push_frame(49, 3'd2, 1'b0, 1'b0, 40'h0);
        drain(1'b0, 300, "full_frame");
        checks++;
        if (bank_full !== 2'b00) begin
            errors++;
            $display("FAIL t1_bank_full: got %b need 00", bank_full);
        end
    endtask

    // Two frames fill both banks behind a stalled reader; writes while full are dropped
    task automatic test_back_to_back();
        int n = 0;
        int hits = 0;
        push_frame(10, 3'd3, 1'b1, 1'b0, 40'h10_0000_0000);
        push_frame(20, 3'd5, 1'b1, 1'b0, 40'h20_0000_0000);
        while (wq.size() > 0 && n < 200) begin
            step(1'b0);
            n++;
        end
        repeat (4) step(1'b0);
        checks += 4;
        if (full !== 1'b1) begin errors++; $display("FAIL t2_full: got %b need 1", full); end
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL t2_wr_ready: got %b need 0", wr_ready); end
        if (bank_full !== 2'b11) begin errors++; $display("FAIL t2_bank_full: got %b need 11", bank_full); end
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL t2_rd_valid: got %b need 1", rd_valid); end
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1;
            wr_data  = 40'hDE_ADBE_EF00 + 40'(k);
            wr_last  = (k == 5);
            wr_layer = 3'd7;
            if (wr_ready !== 1'b0) hits++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL t6_ready_when_full: got %0d ready cycles, need 0", hits);
        end
        chk_rise = 1'b1;
        drain(1'b0, 300, "back_to_back");
        push_frame(4, 3'd6, 1'b1, 1'b0, 40'h30_0000_0000);
        drain(1'b0, 100, "after_full");
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            push_frame($urandom_range(1, 49), 3'($urandom_range(0, 7)), 1'b1, 1'b1, 40'h0);
        end
        drain(1'b1, 6000, "random");
    endtask

    // Single-word frames; the first also measures commit-to-rd_valid latency
    task automatic test_single_word();
        word_t e;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 40'hAA_AAAA_AAAA;
        wr_last  = 1'b1;
        wr_layer = 3'd1;
        e.data = 40'hAA_AAAA_AAAA;
        e.last = 1'b1;
        e.layer = 3'd1;
        eq.push_back(e);
        @(negedge clk);
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checks += 2;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_c1: got %b need 0", rd_valid); end
        if (empty !== 1'b0) begin errors++; $display("FAIL lat_empty: got %b need 0", empty); end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL lat_c2: got %b need 0", rd_valid); end
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_last !== 1'b1) begin
            errors++;
            $display("FAIL lat_c3: got valid=%b last=%b need 1 1", rd_valid, rd_last);
        end
        stalled = 1'b0;
        push_frame(1, 3'd6, 1'b1, 1'b0, 40'h55_5555_5555);
        drain(1'b0, 100, "single_word");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        push_frame(5, 3'd4, 1'b1, 1'b0, 40'h40_0000_0000);
        push_frame(20, 3'd7, 1'b1, 1'b0, 40'h50_0000_0000);
        while (wq.size() > 13 && n < 200) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL t5_streaming: got %b need 1", rd_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (empty !== 1'b1) begin errors++; $display("FAIL t5_empty: got %b need 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL t5_full: got %b need 0", full); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL t5_rd_valid: got %b need 0", rd_valid); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL t5_wr_ready: got %b need 1", wr_ready); end
        if (bank_full !== 2'b00) begin errors++; $display("FAIL t5_bank_full: got %b need 00", bank_full); end
        @(negedge clk);
        wq.delete();
        eq.delete();
        stalled  = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        push_frame(3, 3'd5, 1'b1, 1'b0, 40'h03_0000_0001);
        drain(1'b0, 100, "after_reset");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_random();
        test_single_word();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, need finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
